audio_note_sequencer: RTL

// Processor-side note queue that drives the audio duration interface. Buffers notes
// (pitch, frame duration) written by the processor and issues each one as a 1-cycle

---
 rtl/audio_note_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/audio_note_sequencer.sv
// Note queue feeding the audio duration interface; optional AUDIO_SEQ_OVF_EN adds a sticky overflow flag.
// Latency: start 2 cycles after a push to an idle, empty queue; no backpressure, pushes while full are dropped.
module audio_note_sequencer #(
  parameter int DEPTH      = 8,
  parameter int DUR_W      = 17,
  parameter int PITCH_W    = 8,
  parameter int GAP_FRAMES = 1
) (
  input  logic                   clk25,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DUR_W-1:0]       wr_dur,
  input  logic [PITCH_W-1:0]     wr_pitch,
  input  logic                   frclk,
  input  logic                   audio_en,
  output logic                   start,
  output logic [DUR_W-1:0]       dur,
  output logic [PITCH_W-1:0]     pitch,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   err,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ON, PLAY, GAP} state_t;
  localparam state_t AFTER_NOTE = (GAP_FRAMES == 0) ? IDLE : GAP;

  state_t             state;
  logic [DUR_W-1:0]   mem_dur   [DEPTH];
  logic [PITCH_W-1:0] mem_pitch [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push;
  logic               pop;
  logic [DUR_W-1:0]   head_dur;
  logic [PITCH_W-1:0] head_pitch;
  logic [PITCH_W-1:0] pitch_lat;
  logic [1:0]         timer;
  logic [GW-1:0]      gap_cnt;
  logic               fr_meta;
  logic               fr_sync;
  logic               fr_sync_d;
  logic               frame_tick;

  assign full       = (level == (AW+1)'(DEPTH));
  assign empty      = (level == '0);
  assign push       = wr_en & ~full;
  assign pop        = (state == IDLE) & ~empty;
  assign busy       = (state != IDLE) | ~empty;
  assign head_dur   = mem_dur[rd_ptr];
  assign head_pitch = mem_pitch[rd_ptr];
  assign frame_tick = fr_sync & ~fr_sync_d;

  always_ff @(posedge clk25) begin
    if (push) begin
      mem_dur[wr_ptr]   <= wr_dur;
      mem_pitch[wr_ptr] <= wr_pitch;
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      fr_meta   <= 1'b0;
      fr_sync   <= 1'b0;
      fr_sync_d <= 1'b0;
    end else begin
      fr_meta   <= frclk;
      fr_sync   <= fr_meta;
      fr_sync_d <= fr_sync;
    end
  end

  // Zero-duration notes are popped and discarded without ever reaching ISSUE.
  always_ff @(posedge clk25) begin
    if (reset) begin
      state     <= IDLE;
      start     <= 1'b0;
      dur       <= '0;
      pitch     <= '0;
      pitch_lat <= '0;
      err       <= 1'b0;
      timer     <= '0;
      gap_cnt   <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty && head_dur != '0) begin
            dur       <= head_dur;
            pitch_lat <= head_pitch;
            start     <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_ON;
        end
        WAIT_ON: begin
          if (audio_en) begin
            pitch <= pitch_lat;
            state <= PLAY;
          end else if (timer == 2'd3) begin
            err     <= 1'b1;
            pitch   <= '0;
            gap_cnt <= '0;
            state   <= AFTER_NOTE;
          end else begin
            timer <= timer + 2'd1;
          end
        end
        PLAY: begin
          if (!audio_en) begin
            pitch   <= '0;
            gap_cnt <= '0;
            state   <= AFTER_NOTE;
          end
        end
        GAP: begin
          if (frame_tick) begin
            if (gap_cnt == GW'(GAP_FRAMES - 1)) state <= IDLE;
            else gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AUDIO_SEQ_OVF_EN
  always_ff @(posedge clk25) begin
    if (reset)               ovf <= 1'b0;
    else if (wr_en && full)  ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
